bsg_mem_1rw_sync_mask_write_bit_sched: RTL and testbench

Shares one single-port synchronous bit-masked RAM between two requesters, using round-robin arbitration with a valid/ready handshake. After reset it optionally clears the whole array by writing zeros to every address. It routes each registered read result back to the requester that issued the read. It sits between client logic (e.g. tag/state arrays) and the RAM instance, and drives the RAM's v/w/addr/data/mask pins directly.

---
 rtl/bsg_mem_sched_pkg.sv | 36 +++
 rtl/bsg_mem_sched_rr2.sv | 42 ++++
 rtl/bsg_mem_1rw_sync_mask_write_bit_sched.sv | 144 ++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_sched_pkg.sv
// Shared definitions for the single-port bit-masked RAM scheduler.
//
// Contents:
//   state_e              scheduler mode: CLEAR (zeroing sweep) or RUN (serving clients)
//   safe_clog2()         address width helper; an array of one entry still gets a 1-bit address
//   BSG_MEM_SCHED_REQ_S  macro that declares a packed client request struct for a given
//                        data width and address width (w, addr, data, mask)

`ifndef BSG_MEM_SCHED_PKG_SVH
`define BSG_MEM_SCHED_PKG_SVH

// Declares a packed request struct. The struct is declared inside the module that
// uses it, because its field widths follow that module's parameters.
`define BSG_MEM_SCHED_REQ_S(name, width, aw) \
  typedef struct packed { \
    logic              w; \
    logic [(aw)-1:0]   addr; \
    logic [(width)-1:0] data; \
    logic [(width)-1:0] mask; \
  } name

`endif

package bsg_mem_sched_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // $clog2(1) is 0, which would give a zero-width address bus, so the minimum is 1.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_mem_sched_rr2.sv
// Two-way round-robin grant.
//
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset; rr_last returns to 1 so client 0 wins first
//   v_i[1:0]   request valids
//   yumi_i     a grant was actually taken this cycle; advances the round-robin pointer
//   grant_o    one-hot (or zero) grant, purely combinational from v_i and rr_last

module bsg_mem_sched_rr2 (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] v_i,
  input  logic       yumi_i,
  output logic [1:0] grant_o
);

  logic rr_last;

  // A lone requester always wins. When both request, the one that did not win most
  // recently is chosen, so two busy clients strictly alternate.
  always_comb begin
    grant_o = 2'b00;
    case (v_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_last ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // The pointer moves only when a grant is consumed; idle cycles and cycles where the
  // parent suppresses the grant leave the priority order untouched.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_last <= 1'b1;
    end else if (yumi_i) begin
      rr_last <= grant_o[1];
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_sched.sv
// Shares one single-port synchronous bit-masked RAM between two clients.
//
// After reset the whole array is optionally zeroed (one address per cycle), then the two
// clients are served with round-robin arbitration. Read data from the RAM arrives one cycle
// after the grant and is steered back to the client that issued the read as a one-cycle pulse.
//
// Ports:
//   clk_i, reset_n_i   clock, synchronous active-low reset
//   v_i, w_i           per-client request valid and write(1)/read(0)
//   addr_i, data_i     per-client address and write data
//   w_mask_i           per-client bit write mask (1 = write this bit)
//   ready_o            per-client grant; request accepted when v_i & ready_o
//   r_v_o, r_data_o    read return pulse per client, shared read data
//   init_done_o        high once the clear sweep is over
//   mem_*_o            RAM request pins (v, w, addr, data, mask)
//   mem_data_i         RAM registered read data

module bsg_mem_1rw_sync_mask_write_bit_sched
  import bsg_mem_sched_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int els_p            = 16,
  parameter bit clear_on_reset_p = 1'b1,
  parameter int addr_width_lp    = safe_clog2(els_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [1:0]                    v_i,
  input  logic [1:0]                    w_i,
  input  logic [1:0][addr_width_lp-1:0] addr_i,
  input  logic [1:0][width_p-1:0]       data_i,
  input  logic [1:0][width_p-1:0]       w_mask_i,
  output logic [1:0]                    ready_o,
  output logic [1:0]                    r_v_o,
  output logic [width_p-1:0]            r_data_o,
  output logic                          init_done_o,
  output logic                          mem_v_o,
  output logic                          mem_w_o,
  output logic [addr_width_lp-1:0]      mem_addr_o,
  output logic [width_p-1:0]            mem_data_o,
  output logic [width_p-1:0]            mem_w_mask_o,
  input  logic [width_p-1:0]            mem_data_i
);

  `BSG_MEM_SCHED_REQ_S(req_s, width_p, addr_width_lp);

  req_s [1:0]               req;
  req_s                     sel_req;
  state_e                   state;
  logic [addr_width_lp-1:0] clear_addr;
  logic                     rd_pending;
  logic                     rd_owner;
  logic [1:0]               grant_raw;
  logic                     granted;
  logic                     gnt_idx;
  logic                     run_en;

  // Bundle each client's request fields so the winner can be selected as one unit.
  always_comb begin
    req = '0;
    for (int k = 0; k < 2; k++) begin
      req[k].w    = w_i[k];
      req[k].addr = addr_i[k];
      req[k].data = data_i[k];
      req[k].mask = w_mask_i[k];
    end
  end

  bsg_mem_sched_rr2 rr2 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .yumi_i    (granted),
    .grant_o   (grant_raw)
  );

  // Grants are only exposed in RUN and outside reset; the arbiter itself is unaware of
  // the sweep, so its raw grant is masked here.
  assign run_en  = reset_n_i && (state == RUN);
  assign ready_o = run_en ? grant_raw : 2'b00;
  assign granted = |ready_o;
  assign gnt_idx = ready_o[1];
  assign sel_req = req[gnt_idx];

  // RAM pins: the sweep owns the RAM in CLEAR, the granted client owns it in RUN.
  // Everything is quiet while reset is held, even though reset is synchronous.
  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (reset_n_i) begin
      if (state == CLEAR) begin
        mem_v_o      = 1'b1;
        mem_w_o      = 1'b1;
        mem_addr_o   = clear_addr;
        mem_w_mask_o = '1;
      end else if (granted) begin
        mem_v_o      = 1'b1;
        mem_w_o      = sel_req.w;
        mem_addr_o   = sel_req.addr;
        mem_data_o   = sel_req.data;
        mem_w_mask_o = sel_req.mask;
      end
    end
  end

  // The RAM output is registered, so a read granted in one cycle is returned in the next.
  // The pulse is masked during reset so an in-flight return is dropped immediately.
  assign r_v_o       = (reset_n_i && rd_pending) ? {rd_owner, ~rd_owner} : 2'b00;
  assign r_data_o    = mem_data_i;
  assign init_done_o = (state == RUN);

  // Mode control and read tracking. The sweep writes one address per cycle and hands over
  // to RUN right after the last address is written. rd_pending records that the RAM is
  // returning data this coming cycle, and rd_owner says which client it belongs to.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= clear_on_reset_p ? CLEAR : RUN;
      clear_addr <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rd_pending <= 1'b0;
          clear_addr <= clear_addr + 1'b1;
          if (clear_addr == addr_width_lp'(els_p - 1)) begin
            state <= RUN;
          end
        end
        RUN: begin
          rd_pending <= granted && !sel_req.w;
          if (granted) begin
            rd_owner <= gnt_idx;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_sched.sv
// Testbench for the two-client RAM scheduler, with a behavioural bit-masked RAM attached
// to the mem_* pins. Stimulus pushes expected read returns into a scoreboard queue and
// a separate monitor pops and compares them whenever r_v_o pulses.

module tb_bsg_mem_1rw_sync_mask_write_bit_sched;

  localparam int W  = 8;
  localparam int E  = 16;
  localparam int AW = 4;

  typedef struct {
    bit           client;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [1:0]           v, w;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][W-1:0]    data, mask;
  logic [1:0]           ready, r_v;
  logic [W-1:0]         r_data;
  logic                 init_done;
  logic                 mem_v, mem_w;
  logic [AW-1:0]        mem_addr;
  logic [W-1:0]         mem_data, mem_w_mask;
  logic [W-1:0]         mem_q;
  logic [W-1:0]         ram [E];
  logic                 prefill;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_sched #(
    .width_p          (W),
    .els_p            (E),
    .clear_on_reset_p (1'b1)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .v_i          (v),
    .w_i          (w),
    .addr_i       (addr),
    .data_i       (data),
    .w_mask_i     (mask),
    .ready_o      (ready),
    .r_v_o        (r_v),
    .r_data_o     (r_data),
    .init_done_o  (init_done),
    .mem_v_o      (mem_v),
    .mem_w_o      (mem_w),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .mem_w_mask_o (mem_w_mask),
    .mem_data_i   (mem_q)
  );

  // Behavioural single-port RAM with bit-masked writes and a registered read port,
  // plus the cycle counter used to time-stamp expected read returns.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (prefill) begin
      for (int i = 0; i < E; i++) ram[i] <= 8'hFF;
    end else if (mem_v) begin
      if (mem_w) ram[mem_addr] <= (ram[mem_addr] & ~mem_w_mask) | (mem_data & mem_w_mask);
      else       mem_q <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-return monitor: every r_v_o pulse must match the oldest expected return,
  // and an expected return whose cycle has passed without a pulse is a failure.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (r_v !== 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_r_v: got r_v_o=%b, expected 00 (cycle %0d)", r_v, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("r_v_o", {30'd0, r_v}, e.client ? 32'd2 : 32'd1);
          checkOutput("r_data_o", {24'd0, r_data}, {24'd0, e.data});
          checkOutput("r_cycle", cyc, e.cyc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_r_v: got r_v_o=00, expected pulse for client %0d (cycle %0d)",
                 sb[0].client, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Drives one cycle of requests (starting just after a rising edge), checks the grant
  // and RAM pins mid-cycle, and queues the expected read return for the granted client.
  task automatic applyStimulus(input logic [1:0] v_n, input logic [1:0] w_n,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [W-1:0] m0, input logic [W-1:0] m1,
                               input logic [1:0] exp_ready, input logic [W-1:0] exp_rdata,
                               input bit returns);
    bit idx;
    v = v_n; w = w_n;
    addr[0] = a0; addr[1] = a1;
    data[0] = d0; data[1] = d1;
    mask[0] = m0; mask[1] = m1;
    @(negedge clk);
    checkOutput("ready_o", {30'd0, ready}, {30'd0, exp_ready});
    checkOutput("mem_v_o", {31'd0, mem_v}, {31'd0, |exp_ready});
    if (exp_ready != 2'b00) begin
      idx = exp_ready[1];
      checkOutput("mem_addr_o", {28'd0, mem_addr}, {28'd0, idx ? a1 : a0});
      checkOutput("mem_w_o", {31'd0, mem_w}, {31'd0, w_n[idx]});
      if (w_n[idx]) begin
        checkOutput("mem_data_o", {24'd0, mem_data}, {24'd0, idx ? d1 : d0});
        checkOutput("mem_w_mask_o", {24'd0, mem_w_mask}, {24'd0, idx ? m1 : m0});
      end else if (returns) begin
        sb.push_back('{client: idx, data: exp_rdata, cyc: cyc + 1});
      end
    end
    @(posedge clk); #1;
  endtask

  // Single-client request; the expected grant is simply that client.
  task automatic req1(input bit c, input bit wr, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] m,
                      input logic [W-1:0] exp_rdata, input bit returns);
    logic [1:0] vb;
    vb = c ? 2'b10 : 2'b01;
    applyStimulus(vb, wr ? vb : 2'b00, a, a, d, d, m, m, vb, exp_rdata, returns);
  endtask

  // Checks n consecutive sweep cycles starting at address 0, with both clients
  // requesting so that ready_o staying low is meaningful.
  task automatic checkSweep(input int n);
    v = 2'b11; w = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("sweep_mem_v", {31'd0, mem_v}, 32'd1);
      checkOutput("sweep_mem_w", {31'd0, mem_w}, 32'd1);
      checkOutput("sweep_addr", {28'd0, mem_addr}, i);
      checkOutput("sweep_data", {24'd0, mem_data}, 32'd0);
      checkOutput("sweep_mask", {24'd0, mem_w_mask}, 32'hFF);
      checkOutput("sweep_ready", {30'd0, ready}, 32'd0);
      checkOutput("sweep_init_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic checkResetCycle();
    @(negedge clk);
    checkOutput("rst_mem_v", {31'd0, mem_v}, 32'd0);
    checkOutput("rst_ready", {30'd0, ready}, 32'd0);
    checkOutput("rst_r_v", {30'd0, r_v}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic checkInitDone();
    v = 2'b00;
    @(negedge clk);
    checkOutput("init_done_rise", {31'd0, init_done}, 32'd1);
    checkOutput("idle_mem_v", {31'd0, mem_v}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; prefill = 1'b1;
    v = 2'b11; w = 2'b00; addr = '0; data = '0; mask = '0;
    @(posedge clk); #1;
    prefill = 1'b0;

    // Reset held: quiet RAM pins, no grants, init not done.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
      checkResetCycle();
    end

    // Full clear sweep over 16 addresses, then init_done on the 17th cycle.
    reset_n = 1'b1;
    checkSweep(16);
    checkInitDone();

    // Read back every address (pre-filled with 0xFF, so zeros prove the sweep),
    // alternating clients so both return paths are exercised.
    for (int i = 0; i < E; i++) begin
      req1(i[0], 1'b0, AW'(i), 8'h00, 8'h00, 8'h00, 1'b1);
    end

    // Both clients read continuously: grants alternate starting with client 0.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 8'h00, 8'h00,
                    (k % 2 == 1) ? 2'b10 : 2'b01, 8'h00, 1'b1);
    end

    // Masked writes: 0xA5 then clear the low nibble, read gives 0xA0.
    req1(1'b0, 1'b1, 4'd3, 8'hA5, 8'hFF, 8'h00, 1'b0);
    req1(1'b0, 1'b1, 4'd3, 8'h00, 8'h0F, 8'h00, 1'b0);
    req1(1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 8'hA0, 1'b1);

    // Client 1 back-to-back reads of one address while client 0 is idle.
    req1(1'b1, 1'b1, 4'd5, 8'h3C, 8'hFF, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) req1(1'b1, 1'b0, 4'd5, 8'h00, 8'h00, 8'h3C, 1'b1);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    checkOutput("sb_drained_run", sb.size(), 32'd0);

    // In-flight read dropped by reset; this read also leaves client 1 as the next winner.
    req1(1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 8'hA0, 1'b0);
    reset_n = 1'b0;
    checkResetCycle();
    checkResetCycle();

    // Sweep interrupted at address 7, then restarted from 0 for a full 16 cycles.
    reset_n = 1'b1;
    checkSweep(7);
    reset_n = 1'b0;
    checkResetCycle();
    reset_n = 1'b1;
    checkSweep(16);
    checkInitDone();

    // Round-robin pointer is back at its reset value: client 0 wins first again,
    // and the cleared array returns zeros at the addresses written earlier.
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd5, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 1'b1);
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd5, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00, 1'b1);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    checkOutput("sb_drained_end", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
